// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   state_t          : fetch FSM states (FETCH, WAIT, HOLD)
//   DEFAULT_RESET_PC : default first fetch address after reset
//   INSTR_BYTES      : size of one instruction word in bytes
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its environment.
//   branch_taken/branch_addr           : redirect request and target
//   imem_req/imem_addr/imem_ready      : fetch request to instruction memory
//   imem_rvalid/imem_rdata             : read data return
//   instr_valid/instr/instr_pc         : held instruction to downstream
//   instr_ready                        : downstream consume handshake
//   pc_plus4                           : current PC + 4
// Modport master is the sequencer side, slave is the environment side.
interface fetch_sequencer_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  branch_taken;
  logic [DATA_WIDTH-1:0] branch_addr;
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_ready;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] pc_plus4;

  modport master (
    input  branch_taken, branch_addr, imem_ready, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4
  );

  modport slave (
    output branch_taken, branch_addr, imem_ready, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4
  );

endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter register with +4 incrementer and redirect mux.
//   clk, reset : clock and synchronous active-high reset
//   load       : advance pc to pc + 4
//   redirect   : load pc from target (takes priority over load)
//   target     : redirect address; low two bits are cleared on load
//   pc         : current program counter
//   pc_plus4   : pc + 4, combinational, wraps modulo 2^DATA_WIDTH
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] target,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4
);

  // Clears the byte-offset bits so a redirect always lands on a word boundary.
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~(DATA_WIDTH'(INSTR_BYTES - 32'd1));

  logic [DATA_WIDTH-1:0] pc_r;
  logic [DATA_WIDTH-1:0] pc_plus4_s;
  logic [DATA_WIDTH-1:0] target_aligned_s;

  assign pc_plus4_s       = pc_r + DATA_WIDTH'(INSTR_BYTES);
  assign target_aligned_s = target & ALIGN_MASK;
  assign pc               = pc_r;
  assign pc_plus4         = pc_plus4_s;

  // PC register: redirect wins over sequential advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (redirect) begin
      pc_r <= target_aligned_s;
    end else if (load) begin
      pc_r <= pc_plus4_s;
    end else begin
      pc_r <= pc_r;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer.
//   clk, reset : clock and synchronous active-high reset
//   bus        : fetch_sequencer_if master modport (redirect input,
//                instruction memory request/response, held instruction
//                handshake to downstream, pc_plus4)
// FETCH issues a request at pc; WAIT waits for the single outstanding
// response; HOLD presents the instruction until it is consumed or a
// redirect abandons it. A redirect while a response is still in flight
// sets squash so that stale data is dropped.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_sequencer_if.master    bus
);

  state_t                state_r;
  state_t                state_s;
  logic                  squash_r;
  logic                  squash_s;
  logic                  capture_s;
  logic                  redirect_s;
  logic                  advance_s;
  logic                  instr_valid_r;
  logic [DATA_WIDTH-1:0] instr_r;
  logic [DATA_WIDTH-1:0] instr_pc_r;
  logic [DATA_WIDTH-1:0] pc_s;
  logic [DATA_WIDTH-1:0] pc_plus4_s;

  fetch_pc_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (advance_s),
    .redirect (redirect_s),
    .target   (bus.branch_addr),
    .pc       (pc_s),
    .pc_plus4 (pc_plus4_s)
  );

  // The request is gated by reset so nothing is issued during a reset cycle.
  assign bus.imem_req    = (state_r == FETCH) && !reset;
  assign bus.imem_addr   = pc_s;
  assign bus.pc_plus4    = pc_plus4_s;
  assign bus.instr_valid = instr_valid_r;
  assign bus.instr       = instr_r;
  assign bus.instr_pc    = instr_pc_r;

  // Next-state, squash and pc control decode.
  always_comb begin
    state_s    = state_r;
    squash_s   = squash_r;
    capture_s  = 1'b0;
    redirect_s = 1'b0;
    advance_s  = 1'b0;
    case (state_r)
      FETCH: begin
        if (bus.branch_taken) begin
          redirect_s = 1'b1;
          if (bus.imem_ready) begin
            // Request at the old pc was accepted; its data must be dropped.
            squash_s = 1'b1;
            state_s  = WAIT;
          end else begin
            state_s = FETCH;
          end
        end else if (bus.imem_ready) begin
          state_s = WAIT;
        end else begin
          state_s = FETCH;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          squash_s = 1'b0;
          if (bus.branch_taken) begin
            redirect_s = 1'b1;
            state_s    = FETCH;
          end else if (squash_r) begin
            state_s = FETCH;
          end else begin
            capture_s = 1'b1;
            state_s   = HOLD;
          end
        end else if (bus.branch_taken) begin
          redirect_s = 1'b1;
          squash_s   = 1'b1;
          state_s    = WAIT;
        end else begin
          state_s = WAIT;
        end
      end
      HOLD: begin
        if (bus.branch_taken) begin
          redirect_s = 1'b1;
          state_s    = FETCH;
        end else if (bus.instr_ready) begin
          advance_s = 1'b1;
          state_s   = FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s  = FETCH;
        squash_s = 1'b0;
      end
    endcase
  end

  // FSM state and squash flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= FETCH;
      squash_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      squash_r <= squash_s;
    end
  end

  // Held instruction registers; instr_valid tracks entry into HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_valid_r <= 1'b0;
      instr_r       <= '0;
      instr_pc_r    <= '0;
    end else begin
      instr_valid_r <= (state_s == HOLD);
      if (capture_s) begin
        instr_r    <= bus.imem_rdata;
        instr_pc_r <= pc_s;
      end else begin
        instr_r    <= instr_r;
        instr_pc_r <= instr_pc_r;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] baddr;
    logic        irdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        push;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_instr_t;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  exp_instr_t sb[$];
  logic prev_iv;

  fetch_sequencer_if #(.DATA_WIDTH(32)) ifa ();
  fetch_sequencer_if #(.DATA_WIDTH(32)) ifb ();

  fetch_sequencer #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset_a), .bus(ifa.master));

  fetch_sequencer #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .reset(reset_b), .bus(ifb.master));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                              input logic [31:0] rdata, input logic br,
                              input logic [31:0] baddr, input logic irdy,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_instr,
                              input logic [31:0] e_ipc, input logic push);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.br = br;
    v.baddr = baddr; v.irdy = irdy; v.e_req = e_req; v.e_addr = e_addr;
    v.e_iv = e_iv; v.e_instr = e_instr; v.e_ipc = e_ipc; v.push = push;
    return v;
  endfunction

  task automatic drive_b(input logic rdy, input logic rv, input logic [31:0] rdata,
                         input logic irdy);
    ifb.imem_ready   = rdy;
    ifb.imem_rvalid  = rv;
    ifb.imem_rdata   = rdata;
    ifb.instr_ready  = irdy;
    ifb.branch_taken = 1'b0;
    ifb.branch_addr  = 32'h0000_0000;
  endtask

  initial begin
    exp_instr_t e;
    ifa.branch_taken = 1'b0; ifa.branch_addr = 32'h0; ifa.imem_ready = 1'b0;
    ifa.imem_rvalid = 1'b0; ifa.imem_rdata = 32'h0; ifa.instr_ready = 1'b0;
    drive_b(1'b0, 1'b0, 32'h0, 1'b0);
    reset_a = 1'b1;
    reset_b = 1'b1;
    prev_iv = 1'b0;

    //        rst   rdy   rv    rdata          br    baddr          irdy  req   addr           iv    instr          ipc            push
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,   1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         32'h0,   1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'hE3A02005,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,   1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'hE3A02005,  32'h0,   1'b0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         1'b0, 32'hE3A02005,  32'h0,   1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         1'b0, 32'hE3A02005,  32'h0,   1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h42,        1'b0, 1'b0, 32'h4,         1'b0, 32'hE3A02005,  32'h0,   1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 32'h0,         1'b0, 1'b0, 32'h40,        1'b0, 32'hE3A02005,  32'h0,   1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h40,        1'b0, 32'hE3A02005,  32'h0,   1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h40,        1'b0, 32'hE3A02005,  32'h0,   1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h11112222,  1'b0, 32'h0,         1'b0, 1'b0, 32'h40,        1'b0, 32'hE3A02005,  32'h0,   1'b1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b0, 1'b0, 32'h40,        1'b1, 32'h11112222,  32'h40,  1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       1'b1, 1'b0, 32'h40,        1'b1, 32'h11112222,  32'h40,  1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h100,       1'b0, 32'h11112222,  32'h40,  1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h203,       1'b0, 1'b1, 32'h100,       1'b0, 32'h11112222,  32'h40,  1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h300,       1'b0, 1'b1, 32'h200,       1'b0, 32'h11112222,  32'h40,  1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h55,        1'b0, 32'h0,         1'b0, 1'b0, 32'h300,       1'b0, 32'h11112222,  32'h40,  1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h300,       1'b0, 32'h11112222,  32'h40,  1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h66,        1'b1, 32'h407,       1'b0, 1'b0, 32'h300,       1'b0, 32'h11112222,  32'h40,  1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h404,       1'b0, 32'h11112222,  32'h40,  1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h77,        1'b0, 32'h0,         1'b0, 1'b0, 32'h404,       1'b0, 32'h11112222,  32'h40,  1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h404,       1'b1, 32'h77,        32'h404, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h408,       1'b0, 32'h77,        32'h404, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h408,       1'b0, 32'h77,        32'h404, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h408,       1'b0, 32'h77,        32'h404, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h99,        1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         32'h0,   1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         32'h0,   1'b0));

    // Two reset edges before the table so every DUT register is defined.
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset_a          = tbl[i].rst;
      ifa.imem_ready   = tbl[i].rdy;
      ifa.imem_rvalid  = tbl[i].rv;
      ifa.imem_rdata   = tbl[i].rdata;
      ifa.branch_taken = tbl[i].br;
      ifa.branch_addr  = tbl[i].baddr;
      ifa.instr_ready  = tbl[i].irdy;
      #1;
      chk($sformatf("v%0d imem_req", i),    {31'd0, ifa.imem_req},    {31'd0, tbl[i].e_req});
      chk($sformatf("v%0d imem_addr", i),   ifa.imem_addr,            tbl[i].e_addr);
      chk($sformatf("v%0d pc_plus4", i),    ifa.pc_plus4,             tbl[i].e_addr + 32'd4);
      chk($sformatf("v%0d instr_valid", i), {31'd0, ifa.instr_valid}, {31'd0, tbl[i].e_iv});
      chk($sformatf("v%0d instr", i),       ifa.instr,                tbl[i].e_instr);
      chk($sformatf("v%0d instr_pc", i),    ifa.instr_pc,             tbl[i].e_ipc);
      if (tbl[i].push) begin
        e.instr = tbl[i].rdata;
        e.pc    = tbl[i].e_addr;
        sb.push_back(e);
      end
      // Scoreboard: each new held instruction must match the oldest accepted fetch.
      if (ifa.instr_valid === 1'b1 && prev_iv !== 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got instr %h expected none", ifa.instr);
        end else begin
          e = sb.pop_front();
          chk($sformatf("sb%0d instr", i), ifa.instr, e.instr);
          chk($sformatf("sb%0d instr_pc", i), ifa.instr_pc, e.pc);
        end
      end
      prev_iv = ifa.instr_valid;
    end
    chk("sb_drained", sb.size(), 32'd0);

    // PC wrap: RESET_PC = FFFF_FFFC, one instruction consumed.
    @(negedge clk);
    drive_b(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("wrap reset imem_req", {31'd0, ifb.imem_req}, 32'd0);
    @(negedge clk);
    reset_b = 1'b0;
    drive_b(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("wrap first imem_req", {31'd0, ifb.imem_req}, 32'd1);
    chk("wrap first imem_addr", ifb.imem_addr, 32'hFFFF_FFFC);
    chk("wrap pc_plus4", ifb.pc_plus4, 32'h0000_0000);
    @(negedge clk);
    drive_b(1'b0, 1'b1, 32'hCAFE_0001, 1'b0);
    #1;
    chk("wrap wait imem_req", {31'd0, ifb.imem_req}, 32'd0);
    @(negedge clk);
    drive_b(1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("wrap hold instr_valid", {31'd0, ifb.instr_valid}, 32'd1);
    chk("wrap hold instr", ifb.instr, 32'hCAFE_0001);
    chk("wrap hold instr_pc", ifb.instr_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    drive_b(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("wrap next imem_req", {31'd0, ifb.imem_req}, 32'd1);
    chk("wrap next imem_addr", ifb.imem_addr, 32'h0000_0000);
    chk("wrap next instr_valid", {31'd0, ifb.instr_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of PC, addresses and instruction words.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have one clock and a synchronous, active-high reset, on ports clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 branch_taken  input  1  redirect request, PCSrc equivalent.
REQ-007 branch_addr  input  DATA_WIDTH  redirect target.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  DATA_WIDTH  fetch address, equal to current PC.
REQ-010 imem_ready  input  1  memory accepts the request this cycle.
REQ-011 imem_rvalid  input  1  read data valid.
REQ-012 imem_rdata  input  DATA_WIDTH  read data.
REQ-013 instr_valid  output  1  held instruction available downstream.
REQ-014 instr  output  DATA_WIDTH  held instruction word.
REQ-015 instr_pc  output  DATA_WIDTH  address of the held instruction.
REQ-016 instr_ready  input  1  downstream consumes the instruction.
REQ-017 pc_plus4  output  DATA_WIDTH  current PC + 4.

Function
REQ-018 SHALL use three FSM states: FETCH, WAIT, HOLD. At most one memory request is outstanding.
REQ-019 FETCH: imem_req=1, imem_addr=pc. If imem_ready=1, go to WAIT; otherwise stay in FETCH.
REQ-020 WAIT: imem_req=0. On imem_rvalid=1 with squash=0, register instr<=imem_rdata and instr_pc<=pc, then go to HOLD. instr_valid=1 from the next cycle.
REQ-021 HOLD: instr_valid=1, and instr and instr_pc stay stable. On instr_ready=1, set pc<=pc+4 and go to FETCH.
REQ-022 Latency: request accepted in cycle N, rvalid in cycle M, instr_valid in cycle M+1. The next request is issued in the cycle after the HOLD handshake.
REQ-023 Redirect in FETCH, no imem_ready: pc<=branch_addr, stay in FETCH. imem_addr changes only on a redirect.
REQ-024 Redirect in FETCH with imem_ready: pc<=branch_addr, squash<=1, go to WAIT.
REQ-025 Redirect in WAIT, no rvalid: pc<=branch_addr, squash<=1, stay in WAIT.
REQ-026 WAIT with rvalid and squash=1: discard data, squash<=0, go to FETCH.
REQ-027 WAIT with rvalid and redirect in the same cycle: discard data, pc<=branch_addr, go to FETCH. squash stays 0.
REQ-028 Redirect in HOLD: pc<=branch_addr (redirect wins over pc+4), go to FETCH. The held instruction counts as consumed only if instr_ready=1 in that cycle. instr_valid=0 in the next cycle.
REQ-029 branch_addr[1:0] SHALL be forced to 2'b00 when loaded into pc.
REQ-030 pc+4 SHALL wrap modulo 2^DATA_WIDTH, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-031 pc_plus4 SHALL be combinational from pc.
REQ-032 instr_valid SHALL be 1 only in HOLD.

Reset
REQ-033 While reset=1 at a clock edge, the block SHALL set: state=FETCH, pc=RESET_PC, squash=0, instr_valid=0, instr=0, instr_pc=0.
REQ-034 imem_req SHALL be 0 in any cycle in which reset=1.
REQ-035 The first request SHALL go out, with imem_addr=RESET_PC, in the first cycle after reset deasserts.
REQ-036 Reset in WAIT or HOLD SHALL abandon the transaction. A later imem_rvalid while in FETCH SHALL be ignored.

Structure
REQ-037 Package fetch_pkg SHALL hold: the state enum typedef (FETCH, WAIT, HOLD), the RESET_PC default, and constant INSTR_BYTES=4.
REQ-038 Sub-module fetch_pc_unit SHALL hold the pc register, the +4 incrementer and the redirect mux. Its inputs are load, redirect and target; its outputs are pc and pc_plus4.
REQ-039 All state SHALL use always_ff on clk, and next-state logic SHALL use always_comb.

Verification
REQ-040 Reset, then imem_ready=1 and rvalid one cycle later with rdata=32'hE3A02005, instr_ready=1 -> imem_addr=0; instr_valid with instr=32'hE3A02005, instr_pc=0; next imem_addr=4.
REQ-041 imem_ready held at 0 for 3 cycles -> imem_req stays 1, imem_addr stays stable, no state change.
REQ-042 Branch to 32'h0000_0042 while in WAIT, then rvalid -> data discarded, instr_valid stays 0, next imem_addr=32'h0000_0040.
REQ-043 instr_ready=0 for 4 cycles in HOLD -> instr and instr_pc stable, imem_req=0. Then a branch with instr_ready=1 -> next imem_addr=branch target.
REQ-044 RESET_PC=32'hFFFF_FFFC, one instruction consumed -> next imem_addr=32'h0000_0000.
REQ-045 Reset asserted in WAIT, stray rvalid after release -> imem_addr=RESET_PC, instr_valid=0.
